// File: rtl/bcd_counter_scan_display.sv
// N-digit BCD up/down counter with prescaled stepping, parallel load and a
// time-multiplexed, active-low 7-segment scan output with leading-zero blanking.
module bcd_counter_scan_display #(
  parameter int N_DIGITS = 4,
  parameter int TICK_DIV = 12_499_999,
  parameter int SCAN_DIV = 49_999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic                  blank_lz,
  output logic [4*N_DIGITS-1:0] bcd_out,
  output logic                  wrap,
  output logic [7:0]            segmentos,
  output logic [N_DIGITS-1:0]   sel_seg
);

  localparam int W  = 4 * N_DIGITS;
  localparam int PW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int SW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PW-1:0]       presc_reg;
  logic [SW-1:0]       scan_cnt_reg;
  logic [IW-1:0]       idx_reg;
  logic [W-1:0]        bcd_reg;
  logic                wrap_reg;
  logic [7:0]          seg_reg;
  logic [N_DIGITS-1:0] sel_reg;

  logic                tick;
  logic [N_DIGITS:0]   carry;
  logic [N_DIGITS:0]   borrow;
  logic [W-1:0]        inc_val;
  logic [W-1:0]        dec_val;
  logic [W-1:0]        sat_val;
  logic [N_DIGITS-1:0] zero_dig;
  logic [N_DIGITS-1:0] zero_from;

  assign tick      = en && (presc_reg == PW'(TICK_DIV));
  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  // Ripple carry/borrow per digit; zero_from[i] means digits i..top are all zero.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic [3:0] dig;
      logic [3:0] lv;
      assign dig = bcd_reg[4*gi +: 4];
      assign lv  = load_val[4*gi +: 4];

      assign carry[gi+1]  = carry[gi] && (dig == 4'd9);
      assign borrow[gi+1] = borrow[gi] && (dig == 4'd0);

      assign inc_val[4*gi +: 4] = !carry[gi]  ? dig : ((dig == 4'd9) ? 4'd0 : dig + 4'd1);
      assign dec_val[4*gi +: 4] = !borrow[gi] ? dig : ((dig == 4'd0) ? 4'd9 : dig - 4'd1);
      assign sat_val[4*gi +: 4] = (lv > 4'd9) ? 4'd9 : lv;

      assign zero_dig[gi] = (dig == 4'd0);
      if (gi == N_DIGITS - 1) begin : g_top
        assign zero_from[gi] = zero_dig[gi];
      end else begin : g_low
        assign zero_from[gi] = zero_dig[gi] && zero_from[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_reg   <= '0;
      presc_reg <= '0;
      wrap_reg  <= 1'b0;
    end else if (load) begin
      bcd_reg   <= sat_val;
      presc_reg <= '0;
      wrap_reg  <= 1'b0;
    end else if (tick) begin
      presc_reg <= '0;
      bcd_reg   <= up_down ? inc_val : dec_val;
      wrap_reg  <= up_down ? carry[N_DIGITS] : borrow[N_DIGITS];
    end else begin
      wrap_reg <= 1'b0;
      if (en) presc_reg <= presc_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
    end else if (scan_cnt_reg == SW'(SCAN_DIV)) begin
      scan_cnt_reg <= '0;
      idx_reg      <= (idx_reg == IW'(N_DIGITS - 1)) ? '0 : idx_reg + IW'(1);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SW'(1);
    end
  end

  logic [3:0]          cur_digit;
  logic                cur_blank;
  logic [7:0]          seg_code;
  logic [7:0]          seg_next;
  logic [N_DIGITS-1:0] sel_next;

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    sel_next  = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_reg == IW'(i)) begin
        cur_digit   = bcd_reg[4*i +: 4];
        cur_blank   = blank_lz && (i != 0) && zero_from[i];
        sel_next[i] = 1'b0;
      end
    end
  end

  always_comb begin
    seg_code = 8'hFF;
    case (cur_digit)
      4'd0: seg_code = 8'hC0;
      4'd1: seg_code = 8'hF9;
      4'd2: seg_code = 8'hA4;
      4'd3: seg_code = 8'hB0;
      4'd4: seg_code = 8'h99;
      4'd5: seg_code = 8'h92;
      4'd6: seg_code = 8'h82;
      4'd7: seg_code = 8'hF8;
      4'd8: seg_code = 8'h80;
      4'd9: seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
    seg_next = cur_blank ? 8'hFF : seg_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_reg <= 8'hFF;
      sel_reg <= '1;
    end else begin
      seg_reg <= seg_next;
      sel_reg <= sel_next;
    end
  end

  assign bcd_out   = bcd_reg;
  assign wrap      = wrap_reg;
  assign segmentos = seg_reg;
  assign sel_seg   = sel_reg;

endmodule

// File: tb/tb_bcd_counter_scan_display.sv
// Bench for bcd_counter_scan_display: integer-valued reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_bcd_counter_scan_display;

  localparam int N  = 3;
  localparam int TD = 3;
  localparam int SD = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          up_down = 1'b1;
  logic          load = 1'b0;
  logic [4*N-1:0] load_val = '0;
  logic          blank_lz = 1'b0;
  logic [4*N-1:0] bcd_out;
  logic          wrap;
  logic [7:0]    segmentos;
  logic [N-1:0]  sel_seg;

  int checks = 0;
  int failures = 0;

  bcd_counter_scan_display #(.N_DIGITS(N), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .blank_lz(blank_lz), .bcd_out(bcd_out), .wrap(wrap),
    .segmentos(segmentos), .sel_seg(sel_seg)
  );

  always #5 clk = ~clk;

  // Reference model: the count is a plain integer 0..999.
  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int         m_val, m_presc, m_scan, m_idx;
  logic       m_wrap;
  logic [7:0] m_seg;
  logic [N-1:0] m_sel;
  bit         m_valid = 0;

  function automatic int pow10(input int e);
    int r = 1;
    for (int k = 0; k < e; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*N-1:0] to_bcd(input int v);
    logic [4*N-1:0] r = '0;
    for (int d = 0; d < N; d++) r[4*d +: 4] = 4'((v / pow10(d)) % 10);
    return r;
  endfunction

  function automatic int sat_load(input logic [4*N-1:0] lv);
    int r = 0;
    for (int d = 0; d < N; d++) begin
      int nib = int'(lv[4*d +: 4]);
      if (nib > 9) nib = 9;
      r = r + nib * pow10(d);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_val = 0; m_presc = 0; m_scan = 0; m_idx = 0; m_wrap = 0;
      m_seg = 8'hFF; m_sel = '1; m_valid = 1;
    end else begin
      m_sel = '1;
      m_sel[m_idx] = 1'b0;
      if (blank_lz && m_idx > 0 && m_val < pow10(m_idx)) m_seg = 8'hFF;
      else m_seg = seg_tab[(m_val / pow10(m_idx)) % 10];
      if (load) begin
        m_val = sat_load(load_val); m_presc = 0; m_wrap = 0;
      end else if (en && m_presc == TD) begin
        m_presc = 0;
        if (up_down) begin
          m_wrap = (m_val == pow10(N) - 1);
          m_val = m_wrap ? 0 : m_val + 1;
        end else begin
          m_wrap = (m_val == 0);
          m_val = m_wrap ? pow10(N) - 1 : m_val - 1;
        end
      end else begin
        m_wrap = 0;
        if (en) m_presc = m_presc + 1;
      end
      if (m_scan == SD) begin
        m_scan = 0;
        m_idx = (m_idx + 1) % N;
      end else m_scan = m_scan + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks += 4;
      if (bcd_out !== to_bcd(m_val)) begin
        failures++;
        $display("FAIL model_bcd t=%0t got=%h want=%h", $time, bcd_out, to_bcd(m_val));
      end
      if (wrap !== m_wrap) begin
        failures++;
        $display("FAIL model_wrap t=%0t got=%b want=%b", $time, wrap, m_wrap);
      end
      if (segmentos !== m_seg) begin
        failures++;
        $display("FAIL model_seg t=%0t got=%h want=%h", $time, segmentos, m_seg);
      end
      if (sel_seg !== m_sel) begin
        failures++;
        $display("FAIL model_sel t=%0t got=%b want=%b", $time, sel_seg, m_sel);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Observe one full scan rotation twice and check each digit's segments.
  task automatic scan_chk(input string name, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2);
    repeat (6) begin
      cyc(1);
      case (sel_seg)
        3'b110:  chk({name, "_d0"}, 16'(segmentos), 16'(e0));
        3'b101:  chk({name, "_d1"}, 16'(segmentos), 16'(e1));
        3'b011:  chk({name, "_d2"}, 16'(segmentos), 16'(e2));
        default: chk({name, "_sel"}, 16'(sel_seg), 16'h0);
      endcase
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_bcd", 16'(bcd_out), 16'h000);
    chk("rst_wrap", 16'(wrap), 16'h0);
    chk("rst_seg", 16'(segmentos), 16'hFF);
    chk("rst_sel", 16'(sel_seg), 16'h7);
    rst = 0; en = 1; up_down = 1;
    cyc(1);
    chk("post_rst_sel", 16'(sel_seg), 16'h6);
    chk("post_rst_seg", 16'(segmentos), 16'hC0);
    cyc(35);
    chk("up_009", 16'(bcd_out), 16'h009);
    cyc(4);
    chk("up_010", 16'(bcd_out), 16'h010);

    load = 1; load_val = 12'h999;
    cyc(1);
    load = 0;
    chk("load_999", 16'(bcd_out), 16'h999);
    cyc(3);
    chk("hold_999", 16'(bcd_out), 16'h999);
    cyc(1);
    chk("wrap_up_val", 16'(bcd_out), 16'h000);
    chk("wrap_up_flag", 16'(wrap), 16'h1);
    cyc(1);
    chk("wrap_up_clear", 16'(wrap), 16'h0);
    up_down = 0;
    cyc(3);
    chk("wrap_dn_val", 16'(bcd_out), 16'h999);
    chk("wrap_dn_flag", 16'(wrap), 16'h1);

    cyc(3);
    load = 1; load_val = 12'h3A7;
    cyc(1);
    load = 0;
    chk("load_sat", 16'(bcd_out), 16'h397);
    chk("load_wrap", 16'(wrap), 16'h0);
    cyc(3);
    chk("presc_restart", 16'(bcd_out), 16'h397);
    cyc(1);
    chk("next_step", 16'(bcd_out), 16'h396);

    en = 0;
    cyc(20);
    chk("en_hold", 16'(bcd_out), 16'h396);

    load = 1; load_val = 12'h007; blank_lz = 1;
    cyc(1);
    load = 0;
    cyc(1);
    scan_chk("blank_on", 8'hF8, 8'hFF, 8'hFF);
    blank_lz = 0;
    cyc(1);
    scan_chk("blank_off", 8'hF8, 8'hC0, 8'hC0);
    load = 1; load_val = 12'h000; blank_lz = 1;
    cyc(1);
    load = 0;
    cyc(1);
    scan_chk("zero_blank", 8'hC0, 8'hFF, 8'hFF);

    load = 1; load_val = 12'h456;
    cyc(1);
    load = 0; rst = 1;
    cyc(1);
    chk("mid_rst_bcd", 16'(bcd_out), 16'h000);
    chk("mid_rst_seg", 16'(segmentos), 16'hFF);
    rst = 0;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
